// File: rtl/pacman_game_state_pkg.sv
// Shared types and default tuning constants for the Pac-Man round/life controller.
package pacman_game_state_pkg;

  typedef enum logic [2:0] {IDLE, READY, PLAY, DYING, GAME_OVER} game_state_t;

  localparam int DEF_LIVES_INIT    = 3;
  localparam int DEF_HIT_DIST      = 6;
  localparam int DEF_READY_FRAMES  = 60;
  localparam int DEF_FREEZE_FRAMES = 120;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pacman_game_state_sprite_collide.sv
// Registered proximity test between two sprites: hit_q is high one cycle after
// both axis distances fall below HIT_DIST.
module sprite_collide #(
  parameter int HIT_DIST = 6
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic [8:0] x_a,
  input  logic [8:0] y_a,
  input  logic [8:0] x_b,
  input  logic [8:0] y_b,
  output logic       hit_q
);

  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic [9:0]        adx;
  logic [9:0]        ady;
  logic              near;

  // 10-bit signed differences cover +/-511, so the absolute value never wraps.
  always_comb begin
    dx   = $signed({1'b0, x_a}) - $signed({1'b0, x_b});
    dy   = $signed({1'b0, y_a}) - $signed({1'b0, y_b});
    adx  = dx[9] ? $unsigned(-dx) : $unsigned(dx);
    ady  = dy[9] ? $unsigned(-dy) : $unsigned(dy);
    near = (adx < 10'(HIT_DIST)) && (ady < 10'(HIT_DIST));
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= near;
  end

endmodule

// File: rtl/pacman_game_state.sv
// Round/life controller: catch detection, ready countdown, death freeze and game over.
// Outputs are registered from the next state so they are valid on the first cycle of a state.
module pacman_game_state
  import pacman_game_state_pkg::*;
#(
  parameter int LIVES_INIT    = DEF_LIVES_INIT,
  parameter int HIT_DIST      = DEF_HIT_DIST,
  parameter int READY_FRAMES  = DEF_READY_FRAMES,
  parameter int FREEZE_FRAMES = DEF_FREEZE_FRAMES
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic       start_btn,
  input  logic [8:0] x_pac,
  input  logic [8:0] y_pac,
  input  logic [8:0] x_blue,
  input  logic [8:0] y_blue,
  output logic       round_rst,
  output logic       freeze,
  output logic       hit_pulse,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(max2(max2(READY_FRAMES, FREEZE_FRAMES), 2));
  localparam logic [CNT_W-1:0] READY_LAST  = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);

  game_state_t      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       lives_q, lives_n;
  logic             hit_n;
  logic             hit_q;

  sprite_collide #(.HIT_DIST(HIT_DIST)) u_collide (
    .vga_pix_clk (vga_pix_clk),
    .rst         (rst),
    .x_a         (x_pac),
    .y_a         (y_pac),
    .x_b         (x_blue),
    .y_b         (y_blue),
    .hit_q       (hit_q)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    lives_n = lives_q;
    hit_n   = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_btn) begin
          state_n = READY;
          lives_n = 3'(LIVES_INIT);
        end
      end
      READY: begin
        if (frame_stb) begin
          if (cnt_q == READY_LAST) state_n = PLAY;
          else                     cnt_n   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        // Catches are sampled once per frame; DYING then blocks re-detection.
        if (frame_stb && hit_q) begin
          state_n = DYING;
          hit_n   = 1'b1;
          lives_n = lives_q - 3'd1;
        end
      end
      DYING: begin
        if (frame_stb) begin
          if (cnt_q == FREEZE_LAST) state_n = (lives_q == 3'd0) ? GAME_OVER : READY;
          else                      cnt_n   = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state_q) cnt_n = '0;
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lives_q   <= 3'(LIVES_INIT);
      hit_pulse <= 1'b0;
      round_rst <= 1'b1;
      freeze    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      lives_q   <= lives_n;
      hit_pulse <= hit_n;
      round_rst <= (state_n == IDLE) || (state_n == READY) || (state_n == GAME_OVER);
      freeze    <= (state_n == DYING);
      game_over <= (state_n == GAME_OVER);
    end
  end

  assign lives = lives_q;
  assign state = state_q;

endmodule

// File: tb/tb_pacman_game_state.sv
// Directed bench for pacman_game_state using default parameters (3 lives, HIT_DIST 6,
// 60 ready frames, 120 freeze frames).
module tb_pacman_game_state;
  import pacman_game_state_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_stb = 1'b0;
  logic       start_btn = 1'b0;
  logic [8:0] x_pac = 9'd10, y_pac = 9'd10, x_blue = 9'd200, y_blue = 9'd200;
  logic       round_rst, freeze, hit_pulse, game_over;
  logic [2:0] lives, state;

  int n_vec = 0;
  int n_err = 0;
  int hit_count = 0;
  int h0;

  pacman_game_state dut (
    .vga_pix_clk (clk),
    .rst         (rst),
    .frame_stb   (frame_stb),
    .start_btn   (start_btn),
    .x_pac       (x_pac),
    .y_pac       (y_pac),
    .x_blue      (x_blue),
    .y_blue      (y_blue),
    .round_rst   (round_rst),
    .freeze      (freeze),
    .hit_pulse   (hit_pulse),
    .lives       (lives),
    .game_over   (game_over),
    .state       (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (hit_pulse) hit_count++;

  // driver tasks
  task automatic run_frames(input int n);
    repeat (n) begin
      @(negedge clk); frame_stb = 1'b1;
      @(negedge clk); frame_stb = 1'b0;
    end
  endtask

  task automatic set_pos(input int xp, input int yp, input int xb, input int yb);
    x_pac = 9'(xp); y_pac = 9'(yp); x_blue = 9'(xb); y_blue = 9'(yb);
    @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic lose_life();
    run_frames(60);
    set_pos(50, 50, 52, 53);
    run_frames(1);
    set_pos(10, 10, 200, 200);
    run_frames(120);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
    n_vec++; if (round_rst !== 1'b1) begin n_err++; $display("FAIL reset_round_rst got %b want 1", round_rst); end
    n_vec++; if ({freeze, hit_pulse, game_over} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {freeze, hit_pulse, game_over}); end
    n_vec++; if (lives !== 3'd3) begin n_err++; $display("FAIL reset_lives got %0d want 3", lives); end
  endtask

  task automatic test_idle_hold();
    set_pos(50, 50, 50, 50);
    repeat (1000) @(negedge clk);
    n_vec++; if (state !== IDLE || round_rst !== 1'b1) begin n_err++; $display("FAIL idle_hold state/round_rst got %0d/%b want %0d/1", state, round_rst, IDLE); end
    n_vec++; if (hit_count !== 0 || lives !== 3'd3) begin n_err++; $display("FAIL idle_hold hits/lives got %0d/%0d want 0/3", hit_count, lives); end
    set_pos(10, 10, 200, 200);
  endtask

  task automatic test_start_ready();
    press_start();
    n_vec++; if (state !== READY || round_rst !== 1'b1) begin n_err++; $display("FAIL start state/round_rst got %0d/%b want %0d/1", state, round_rst, READY); end
    repeat (200) @(negedge clk);
    n_vec++; if (state !== READY) begin n_err++; $display("FAIL ready_no_stb state got %0d want %0d", state, READY); end
    run_frames(59);
    n_vec++; if (state !== READY) begin n_err++; $display("FAIL ready_59 state got %0d want %0d", state, READY); end
    run_frames(1);
    n_vec++; if (state !== PLAY || round_rst !== 1'b0) begin n_err++; $display("FAIL ready_60 state/round_rst got %0d/%b want %0d/0", state, round_rst, PLAY); end
  endtask

  task automatic test_catch();
    press_start();
    n_vec++; if (state !== PLAY) begin n_err++; $display("FAIL start_in_play state got %0d want %0d", state, PLAY); end
    h0 = hit_count;
    set_pos(120, 112, 126, 112);
    run_frames(1);
    n_vec++; if (state !== PLAY || lives !== 3'd3 || hit_count !== h0) begin n_err++; $display("FAIL no_catch_dx6 state/lives/hits got %0d/%0d/%0d want %0d/3/%0d", state, lives, hit_count, PLAY, h0); end
    set_pos(120, 112, 125, 112);
    run_frames(1);
    n_vec++; if (hit_pulse !== 1'b1 || lives !== 3'd2 || freeze !== 1'b1) begin n_err++; $display("FAIL catch_dx5 hit/lives/freeze got %b/%0d/%b want 1/2/1", hit_pulse, lives, freeze); end
    @(negedge clk);
    n_vec++; if (hit_pulse !== 1'b0 || state !== DYING) begin n_err++; $display("FAIL catch_pulse_width hit/state got %b/%0d want 0/%0d", hit_pulse, state, DYING); end
    set_pos(10, 10, 200, 200);
  endtask

  task automatic test_dying_to_ready();
    run_frames(119);
    n_vec++; if (state !== DYING || freeze !== 1'b1) begin n_err++; $display("FAIL dying_119 state/freeze got %0d/%b want %0d/1", state, freeze, DYING); end
    run_frames(1);
    n_vec++; if (state !== READY || round_rst !== 1'b1 || freeze !== 1'b0 || lives !== 3'd2) begin n_err++; $display("FAIL dying_120 state/rr/fz/lives got %0d/%b/%b/%0d want %0d/1/0/2", state, round_rst, freeze, lives, READY); end
    run_frames(60);
    n_vec++; if (state !== PLAY) begin n_err++; $display("FAIL replay state got %0d want %0d", state, PLAY); end
  endtask

  task automatic test_overlap_hold();
    h0 = hit_count;
    set_pos(50, 50, 53, 52);
    run_frames(5);
    n_vec++; if (hit_count !== h0 + 1 || lives !== 3'd1 || state !== DYING) begin n_err++; $display("FAIL overlap_hold hits/lives/state got %0d/%0d/%0d want %0d/1/%0d", hit_count, lives, state, h0 + 1, DYING); end
    set_pos(10, 10, 200, 200);
    run_frames(115);
    n_vec++; if (state !== DYING) begin n_err++; $display("FAIL overlap_dying state got %0d want %0d", state, DYING); end
    run_frames(1);
    n_vec++; if (state !== READY) begin n_err++; $display("FAIL overlap_ready state got %0d want %0d", state, READY); end
    run_frames(60);
  endtask

  task automatic test_diagonal_game_over();
    set_pos(100, 105, 105, 100);
    run_frames(1);
    n_vec++; if (hit_pulse !== 1'b1 || lives !== 3'd0 || state !== DYING) begin n_err++; $display("FAIL diagonal hit/lives/state got %b/%0d/%0d want 1/0/%0d", hit_pulse, lives, state, DYING); end
    set_pos(10, 10, 200, 200);
    run_frames(119);
    n_vec++; if (state !== DYING || game_over !== 1'b0) begin n_err++; $display("FAIL last_dying state/go got %0d/%b want %0d/0", state, game_over, DYING); end
    run_frames(1);
    n_vec++; if (state !== GAME_OVER || game_over !== 1'b1 || round_rst !== 1'b1 || freeze !== 1'b0 || lives !== 3'd0) begin n_err++; $display("FAIL game_over st/go/rr/fz/lives got %0d/%b/%b/%b/%0d want %0d/1/1/0/0", state, game_over, round_rst, freeze, lives, GAME_OVER); end
  endtask

  task automatic test_restart_held();
    start_btn = 1'b1;
    @(negedge clk);
    n_vec++; if (state !== READY || lives !== 3'd3 || game_over !== 1'b0) begin n_err++; $display("FAIL restart st/lives/go got %0d/%0d/%b want %0d/3/0", state, lives, game_over, READY); end
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    n_vec++; if (state !== READY) begin n_err++; $display("FAIL restart_held state got %0d want %0d", state, READY); end
  endtask

  task automatic test_rst_dying();
    run_frames(60);
    set_pos(50, 50, 52, 53);
    run_frames(1);
    set_pos(10, 10, 200, 200);
    run_frames(3);
    n_vec++; if (state !== DYING || lives !== 3'd2) begin n_err++; $display("FAIL pre_rst_dying state/lives got %0d/%0d want %0d/2", state, lives, DYING); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (state !== IDLE || lives !== 3'd3 || freeze !== 1'b0 || round_rst !== 1'b1) begin n_err++; $display("FAIL rst_dying st/lives/fz/rr got %0d/%0d/%b/%b want %0d/3/0/1", state, lives, freeze, round_rst, IDLE); end
  endtask

  task automatic test_rst_inflight_hit();
    press_start();
    run_frames(60);
    set_pos(50, 50, 52, 53);
    h0 = hit_count;
    rst = 1'b1; frame_stb = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_stb = 1'b0;
    n_vec++; if (hit_pulse !== 1'b0 || hit_count !== h0 || state !== IDLE || lives !== 3'd3) begin n_err++; $display("FAIL rst_inflight hit/hits/st/lives got %b/%0d/%0d/%0d want 0/%0d/%0d/3", hit_pulse, hit_count, state, lives, h0, IDLE); end
    set_pos(10, 10, 200, 200);
  endtask

  task automatic test_rst_game_over();
    press_start();
    lose_life();
    lose_life();
    lose_life();
    n_vec++; if (state !== GAME_OVER || game_over !== 1'b1 || lives !== 3'd0) begin n_err++; $display("FAIL three_catches st/go/lives got %0d/%b/%0d want %0d/1/0", state, game_over, lives, GAME_OVER); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (state !== IDLE || game_over !== 1'b0 || lives !== 3'd3 || freeze !== 1'b0) begin n_err++; $display("FAIL rst_game_over st/go/lives/fz got %0d/%b/%0d/%b want %0d/0/3/0", state, game_over, lives, freeze, IDLE); end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_start_ready();
    test_catch();
    test_dying_to_ready();
    test_overlap_hold();
    test_diagonal_game_over();
    test_restart_held();
    test_rst_dying();
    test_rst_inflight_hit();
    test_rst_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
